// File: rtl/subway_pkg.sv
// Shared definitions for the ticket-sale datapath: denominations, coin and error
// encodings, and the change-dispenser state encoding.
package subway_pkg;

   localparam int CHANGE_W       = 32;
   localparam int DENOM_HI_VAL   = 10;
   localparam int DENOM_MID_VAL  = 5;
   localparam int DENOM_LO_VAL   = 1;
   localparam int MAX_CHANGE_VAL = 100;

   typedef enum logic [1:0] {
      COIN_LO  = 2'b00,
      COIN_MID = 2'b01,
      COIN_HI  = 2'b10
   } coin_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_UNDERPAY = 2'b01,
      ERR_OVER     = 2'b10,
      ERR_STOCK    = 2'b11
   } err_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SELECT = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   // Piece counters stick at full scale instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/change_dispenser_denom_select.sv
// Greedy denomination picker: largest available denomination not exceeding the
// remaining change.
module denom_select
   import subway_pkg::*;
#(
   parameter int W         = CHANGE_W,
   parameter int DENOM_HI  = DENOM_HI_VAL,
   parameter int DENOM_MID = DENOM_MID_VAL,
   parameter int DENOM_LO  = DENOM_LO_VAL
) (
   input  logic [W-1:0] rem,
   input  logic [2:0]   stock_empty,
   output logic         found,
   output logic [1:0]   coin_type,
   output logic [W-1:0] d
);

   // Priority chain from the high denomination down; bit 2 of stock_empty is hi.
   always_comb begin
      found     = 1'b0;
      coin_type = COIN_LO;
      d         = {W{1'b0}};
      if (!stock_empty[2] && (rem >= W'(DENOM_HI))) begin
         found     = 1'b1;
         coin_type = COIN_HI;
         d         = W'(DENOM_HI);
      end else if (!stock_empty[1] && (rem >= W'(DENOM_MID))) begin
         found     = 1'b1;
         coin_type = COIN_MID;
         d         = W'(DENOM_MID);
      end else if (!stock_empty[0] && (rem >= W'(DENOM_LO))) begin
         found     = 1'b1;
         coin_type = COIN_LO;
         d         = W'(DENOM_LO);
      end else begin
         found     = 1'b0;
         coin_type = COIN_LO;
         d         = {W{1'b0}};
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Issues a registered change amount to the ejector one piece at a time with a
// valid/ready handshake, flagging underpay, over-limit and stock-out.
module change_dispenser
   import subway_pkg::*;
#(
   parameter int W          = CHANGE_W,
   parameter int DENOM_HI   = DENOM_HI_VAL,
   parameter int DENOM_MID  = DENOM_MID_VAL,
   parameter int DENOM_LO   = DENOM_LO_VAL,
   parameter int MAX_CHANGE = MAX_CHANGE_VAL
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] change_in,
   input  logic [2:0]   stock_empty,
   input  logic         coin_ready,
   output logic         coin_valid,
   output logic [1:0]   coin_type,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [1:0]   err_code,
   output logic [W-1:0] shortfall,
   output logic [7:0]   cnt_hi,
   output logic [7:0]   cnt_mid,
   output logic [7:0]   cnt_lo
);

   state_t       state_r;
   state_t       state_next_s;
   logic [W-1:0] rem_r;
   logic [W-1:0] d_r;
   logic [W-1:0] rem_after_s;
   logic         found_s;
   logic [1:0]   sel_type_s;
   logic [W-1:0] sel_d_s;
   logic         underpay_s;
   logic         over_s;
   logic         coin_valid_s;
   logic         busy_s;
   logic         done_s;
   logic         error_s;
   logic         coin_valid_r;
   logic [1:0]   coin_type_r;
   logic         busy_r;
   logic         done_r;
   logic         error_r;
   logic [1:0]   err_code_r;
   logic [W-1:0] shortfall_r;
   logic [7:0]   cnt_hi_r;
   logic [7:0]   cnt_mid_r;
   logic [7:0]   cnt_lo_r;

   denom_select #(
      .W         (W),
      .DENOM_HI  (DENOM_HI),
      .DENOM_MID (DENOM_MID),
      .DENOM_LO  (DENOM_LO)
   ) u_denom_select (
      .rem         (rem_r),
      .stock_empty (stock_empty),
      .found       (found_s),
      .coin_type   (sel_type_s),
      .d           (sel_d_s)
   );

   assign underpay_s  = rem_r[W-1];
   assign over_s      = (rem_r > W'(MAX_CHANGE));
   // d_r was chosen with d <= rem, so this never wraps.
   assign rem_after_s = rem_r - d_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_CHECK;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (underpay_s || over_s) begin
               state_next_s = ST_ERR;
            end else if (rem_r == {W{1'b0}}) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (found_s) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_ERR;
            end
         end
         ST_ISSUE: begin
            if (!coin_ready) begin
               state_next_s = ST_ISSUE;
            end else if (rem_after_s == {W{1'b0}}) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SELECT;
            end
         end
         ST_DONE:  state_next_s = ST_IDLE;
         ST_ERR:   state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Moore outputs, decoded from the upcoming state so they register alongside it.
   always_comb begin
      coin_valid_s = (state_next_s == ST_ISSUE);
      busy_s       = (state_next_s != ST_IDLE);
      done_s       = (state_next_s == ST_DONE);
      error_s      = (state_next_s == ST_ERR);
   end

   // Output flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         coin_valid_r <= coin_valid_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         error_r      <= error_s;
      end
   end

   // Remainder, selected piece, error report and per-denomination counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r       <= {W{1'b0}};
         d_r         <= {W{1'b0}};
         coin_type_r <= COIN_LO;
         err_code_r  <= ERR_NONE;
         shortfall_r <= {W{1'b0}};
         cnt_hi_r    <= 8'd0;
         cnt_mid_r   <= 8'd0;
         cnt_lo_r    <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  rem_r       <= change_in;
                  err_code_r  <= ERR_NONE;
                  shortfall_r <= {W{1'b0}};
                  cnt_hi_r    <= 8'd0;
                  cnt_mid_r   <= 8'd0;
                  cnt_lo_r    <= 8'd0;
               end
            end
            ST_CHECK: begin
               if (underpay_s) begin
                  err_code_r <= ERR_UNDERPAY;
               end else if (over_s) begin
                  err_code_r <= ERR_OVER;
               end
            end
            ST_SELECT: begin
               if (found_s) begin
                  coin_type_r <= sel_type_s;
                  d_r         <= sel_d_s;
               end else begin
                  err_code_r  <= ERR_STOCK;
                  shortfall_r <= rem_r;
               end
            end
            ST_ISSUE: begin
               // Piece and value were latched in SELECT; hopper changes now cannot cancel it.
               if (coin_ready) begin
                  rem_r <= rem_after_s;
                  case (coin_type_r)
                     COIN_HI:  cnt_hi_r  <= sat_inc8(cnt_hi_r);
                     COIN_MID: cnt_mid_r <= sat_inc8(cnt_mid_r);
                     default:  cnt_lo_r  <= sat_inc8(cnt_lo_r);
                  endcase
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign coin_valid = coin_valid_r;
   assign coin_type  = coin_type_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign err_code   = err_code_r;
   assign shortfall  = shortfall_r;
   assign cnt_hi     = cnt_hi_r;
   assign cnt_mid    = cnt_mid_r;
   assign cnt_lo     = cnt_lo_r;

endmodule
